mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 2:1 gate-level multiplexer between two requesters and drives a single downstream consumer. It owns the mux select line and issues per-requester grants. A grant is held across consecutive transfers up to a burst limit, and the mux is handed over with no idle bubble when both sides compete. It sits between two producer ports and one valid/ready sink. The datapath is a WIDTH-bit replication of the 2:1 mux cell, steered by this block's registered select.

---
 rtl/mux_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux: grants one requester at a time, holds it for up to MAX_HOLD accepted transfers under contention.
// Grant/select are registered (1 cycle from request); y and y_valid are combinational; ready=0 freezes the transfer count and the owner.
module mux_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             ready,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    localparam logic [7:0] HOLD = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic       s_q, s_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic       own_req;
    logic       oth_req;
    state_t     oth_state;
    logic       accept;
    logic [7:0] cnt_inc;

    assign gnt0    = (state_q == G0);
    assign gnt1    = (state_q == G1);
    assign s       = s_q;
    assign y_valid = (gnt0 & req0) | (gnt1 & req1);
    assign accept  = y_valid & ready;
    assign cnt_inc = cnt_q + 8'd1;

    // One 2:1 mux cell per bit, all steered by the registered select.
    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        assign y[i] = (d0[i] & ~s_q) | (d1[i] & s_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        last_d    = last_q;
        own_req   = 1'b0;
        oth_req   = 1'b0;
        oth_state = IDLE;

        case (state_q)
            IDLE: begin
                if (req0 && req1) state_d = last_q ? G0 : G1;
                else if (req0)    state_d = G0;
                else if (req1)    state_d = G1;
            end
            G0, G1: begin
                own_req   = (state_q == G0) ? req0 : req1;
                oth_req   = (state_q == G0) ? req1 : req0;
                oth_state = (state_q == G0) ? G1 : G0;
                // Release wins over the hold limit when both happen together.
                if (!own_req) begin
                    state_d = oth_req ? oth_state : IDLE;
                end else if (accept) begin
                    if (cnt_inc == HOLD) begin
                        cnt_d = 8'd0;
                        if (oth_req) state_d = oth_state;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = 8'd0;
            if (state_d == G0) begin
                s_d    = 1'b0;
                last_d = 1'b0;
            end else if (state_d == G1) begin
                s_d    = 1'b1;
                last_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus a long random run against a behavioural owner/count model.
module tb_mux_rr_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             rst;
    logic             req0, req1, ready;
    logic [WIDTH-1:0] d0, d1;
    logic             gnt0, gnt1, s, y_valid;
    logic [WIDTH-1:0] y;

    int checks   = 0;
    int failures = 0;

    // Model: owner 0/1, or 2 for no owner.
    int m_owner;
    int m_cnt;
    int m_last;
    int m_s;

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .ready(ready), .gnt0(gnt0), .gnt1(gnt1), .s(s), .y(y), .y_valid(y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = 2;
        m_cnt   = 0;
        m_last  = 1;
        m_s     = 0;
    endtask

    task automatic model_step();
        int  nxt;
        int  o;
        bit  r[2];
        r[0] = req0;
        r[1] = req1;
        nxt  = m_owner;
        if (m_owner == 2) begin
            if (r[0] && r[1]) nxt = 1 - m_last;
            else if (r[0])    nxt = 0;
            else if (r[1])    nxt = 1;
        end else begin
            o = 1 - m_owner;
            if (!r[m_owner]) begin
                nxt = r[o] ? o : 2;
            end else if (ready) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == MAX_HOLD) begin
                    m_cnt = 0;
                    if (r[o]) nxt = o;
                end
            end
        end
        if (nxt != m_owner) begin
            m_cnt = 0;
            if (nxt != 2) begin
                m_last = nxt;
                m_s    = nxt;
            end
        end
        m_owner = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        ready = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        d0 = 8'h11;
        d1 = 8'h22;
        #1;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b%b want=00", gnt0, gnt1); end
        checks++; if (s !== 1'b0) begin failures++; $display("FAIL reset_s got=%b want=0", s); end
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_yvalid got=%b want=0", y_valid); end
        // Get into G1 mid-transfer, then reset between edges.
        req1  = 1'b1;
        ready = 1'b1;
        #1;
        step();
        checks++; if (gnt1 !== 1'b1 || s !== 1'b1) begin failures++; $display("FAIL reset_preG1 got gnt1=%b s=%b want 1 1", gnt1, s); end
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL reset_async_gnt got=%b%b want=00", gnt0, gnt1); end
        checks++; if (s !== 1'b0) begin failures++; $display("FAIL reset_async_s got=%b want=0", s); end
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_async_yvalid got=%b want=0", y_valid); end
        checks++; if (y !== 8'h11) begin failures++; $display("FAIL reset_async_y got=%h want=11", y); end
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        step();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || s !== 1'b0) begin failures++; $display("FAIL reset_first_tie got gnt=%b%b s=%b want 10 0", gnt0, gnt1, s); end
    endtask

    task automatic test_single();
        int xfers = 0;
        apply_reset();
        req0  = 1'b1;
        req1  = 1'b0;
        ready = 1'b1;
        d0    = 8'h5A;
        d1    = 8'hC3;
        #1;
        step();
        for (int i = 0; i < 10; i++) begin
            d0 = 8'(i + 1);
            #1;
            checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || s !== 1'b0) begin failures++; $display("FAIL single_owner cyc=%0d got gnt=%b%b s=%b want 10 0", i, gnt0, gnt1, s); end
            checks++; if (y !== 8'(i + 1)) begin failures++; $display("FAIL single_y cyc=%0d got=%h want=%h", i, y, 8'(i + 1)); end
            if (y_valid === 1'b1 && ready === 1'b1) xfers++;
            step();
        end
        checks++; if (xfers != 10) begin failures++; $display("FAIL single_xfers got=%0d want=10", xfers); end
    endtask

    task automatic test_contention();
        logic [7:0] exp;
        apply_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        ready = 1'b1;
        d0    = 8'hA5;
        d1    = 8'h3C;
        #1;
        step();
        for (int i = 0; i < 16; i++) begin
            exp = ((i / MAX_HOLD) % 2 == 0) ? 8'hA5 : 8'h3C;
            #1;
            checks++; if (y_valid !== 1'b1 || y !== exp) begin failures++; $display("FAIL contention cyc=%0d got v=%b y=%h want 1 %h", i, y_valid, y, exp); end
            checks++; if (gnt0 === 1'b1 && gnt1 === 1'b1) begin failures++; $display("FAIL contention_onehot cyc=%0d got both grants want one", i); end
            step();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req0  = 1'b1;
        req1  = 1'b0;
        ready = 1'b0;
        d0    = 8'h77;
        d1    = 8'h88;
        #1;
        step();
        req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (gnt0 !== 1'b1 || y !== 8'h77 || y_valid !== 1'b1) begin failures++; $display("FAIL bp_stall cyc=%0d got gnt0=%b y=%h v=%b want 1 77 1", i, gnt0, y, y_valid); end
            step();
        end
        ready = 1'b1;
        for (int i = 0; i < MAX_HOLD; i++) begin
            #1;
            checks++; if (gnt0 !== 1'b1 || s !== 1'b0) begin failures++; $display("FAIL bp_hold acc=%0d got gnt0=%b s=%b want 1 0", i, gnt0, s); end
            step();
        end
        #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || y !== 8'h88) begin failures++; $display("FAIL bp_handover got gnt=%b%b y=%h want 01 88", gnt0, gnt1, y); end
    endtask

    task automatic test_early_release();
        apply_reset();
        req0  = 1'b0;
        req1  = 1'b1;
        ready = 1'b1;
        d0    = 8'h0F;
        d1    = 8'hF0;
        #1;
        step();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (gnt1 !== 1'b1 || y_valid !== 1'b1 || y !== 8'hF0) begin failures++; $display("FAIL early_g1 cyc=%0d got gnt1=%b v=%b y=%h want 1 1 f0", i, gnt1, y_valid, y); end
            step();
        end
        req1 = 1'b0;
        req0 = 1'b1;
        #1;
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL early_drop_valid got=%b want=0", y_valid); end
        step();
        checks++; if (gnt0 !== 1'b1 || s !== 1'b0 || y !== 8'h0F) begin failures++; $display("FAIL early_to_g0 got gnt0=%b s=%b y=%h want 1 0 0f", gnt0, s, y); end
        // A fresh count: handover needs a full MAX_HOLD acceptances.
        req1 = 1'b1;
        for (int i = 0; i < MAX_HOLD; i++) begin
            #1;
            checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL early_fresh_cnt acc=%0d got gnt0=%b want 1", i, gnt0); end
            step();
        end
        checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL early_fresh_handover got gnt1=%b want 1", gnt1); end
        // Release with nobody waiting: idle, select keeps its value.
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
        step();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || s !== 1'b1 || y_valid !== 1'b0) begin failures++; $display("FAIL early_idle got gnt=%b%b s=%b v=%b want 00 1 0", gnt0, gnt1, s, y_valid); end
        checks++; if (y !== 8'hF0) begin failures++; $display("FAIL early_idle_y got=%h want=f0", y); end
    endtask

    task automatic test_random();
        logic             e_g0, e_g1, e_v;
        logic [WIDTH-1:0] e_y;
        apply_reset();
        for (int i = 0; i < 10000; i++) begin
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 2) != 0);
            d0    = WIDTH'($urandom);
            d1    = WIDTH'($urandom);
            #1;
            e_g0 = (m_owner == 0);
            e_g1 = (m_owner == 1);
            e_v  = (e_g0 && req0) || (e_g1 && req1);
            e_y  = (m_s == 1) ? d1 : d0;
            checks++; if (gnt0 !== e_g0 || gnt1 !== e_g1 || s !== 1'(m_s)) begin failures++; $display("FAIL rand_state cyc=%0d got gnt=%b%b s=%b want %b%b %0d", i, gnt0, gnt1, s, e_g0, e_g1, m_s); end
            checks++; if (y_valid !== e_v || y !== e_y) begin failures++; $display("FAIL rand_data cyc=%0d got v=%b y=%h want %b %h", i, y_valid, y, e_v, e_y); end
            step();
        end
    endtask

    initial begin
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        ready = 1'b0;
        d0    = '0;
        d1    = '0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
